pipeline_handshake_ctrl: RTL

Flow-control wrapper for a generated fixed-latency, non-stallable pipeline, such as the 2-stage `x + 1` increment datapath. It sits between a ready/valid producer and consumer and drives the datapath input. It tracks in-flight valids in a shift register and captures datapath results in an output FIFO. It throttles acceptance with an occupancy counter, so no result is lost when the consumer back-pressures.

---
 rtl/pipeline_handshake_ctrl_pkg.sv | 11 +
 rtl/pipeline_handshake_fifo.sv | 50 +++++
 rtl/pipeline_handshake_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/pipeline_handshake_ctrl_pkg.sv
// Shared constants and helpers for the pipeline handshake controller.
`timescale 1ns/1ps
package pipeline_handshake_ctrl_pkg;

  localparam int STAT_WIDTH = 32;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_handshake_fifo.sv
// Synchronous FIFO capturing datapath results; head is read straight from the
// storage flops, so a write into an empty FIFO shows up one cycle later.
`timescale 1ns/1ps
module pipeline_handshake_fifo
  import pipeline_handshake_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic [occ_width(DEPTH)-1:0]   count
);

  localparam int CW = occ_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(do_rd);
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pipeline_handshake_ctrl.sv
// Ready/valid wrapper around a fixed-latency, non-stallable datapath.
// Optional counters enabled by PIPELINE_HANDSHAKE_CTRL_STATS_EN.
`timescale 1ns/1ps
module pipeline_handshake_ctrl
  import pipeline_handshake_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic [WIDTH-1:0]      dp_in,
  input  logic [WIDTH-1:0]      dp_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy
`ifdef PIPELINE_HANDSHAKE_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_accepts,
  output logic [STAT_WIDTH-1:0] stat_stalls
`endif
);

  localparam int DEPTH = LATENCY + 2;
  localparam int OW    = occ_width(DEPTH);

  logic [OW-1:0]      occ;
  logic [OW-1:0]      fifo_count;
  logic [LATENCY-1:0] vld_sr;
  logic               accept;
  logic               pop;

  // Occupancy reserves a FIFO slot at accept time, so the datapath can never
  // deliver a result the FIFO has no room for.
  assign in_ready  = !rst && (occ < OW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign busy      = (occ != '0);
  assign dp_in     = in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      occ    <= '0;
    end else begin
      vld_sr <= (vld_sr << 1) | LATENCY'(accept);
      occ    <= occ + OW'(accept) - OW'(pop);
    end
  end

  pipeline_handshake_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_sr[LATENCY-1]),
    .wr_data (dp_out),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (fifo_count)
  );

`ifdef PIPELINE_HANDSHAKE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepts <= '0;
      stat_stalls  <= '0;
    end else begin
      if (accept)
        stat_accepts <= stat_accepts + STAT_WIDTH'(1);
      if (out_valid && !out_ready)
        stat_stalls <= stat_stalls + STAT_WIDTH'(1);
    end
  end
`endif

endmodule
